// File: rtl/adder_seq_pkg.sv
// Shared types and constants for the nibble-serial adder.
package adder_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIB = 4;

    function automatic int steps(input int w);
        return w / NIB;
    endfunction

endpackage

// File: rtl/adder_seq_nbits_if.sv
// Operand/result handshake bundle for adder_seq_nbits.
interface adder_seq_nbits_if #(
    parameter int W = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         co;
    logic         busy;

    modport master (
        output in_valid, a, b, ci, out_ready,
        input  in_ready, out_valid, s, co, busy
    );

    modport slave (
        input  in_valid, a, b, ci, out_ready,
        output in_ready, out_valid, s, co, busy
    );
endinterface

// File: rtl/adder_4bits.sv
// 4-bit carry-lookahead adder slice; purely combinational.
module adder_4bits (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is expanded directly from ci, no ripple between bits.
    always_comb begin
        c    = '0;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);
    end

    assign s  = p ^ c[3:0];
    assign co = c[4];
endmodule

// File: rtl/adder_seq_nbits.sv
// W-bit adder that reuses one 4-bit lookahead slice over W/4 cycles,
// least-significant nibble first, with the slice carry held in c_q between steps.
module adder_seq_nbits
    import adder_seq_pkg::*;
#(
    parameter int W = 16
) (
    input  logic              clk,
    input  logic              rst,
    adder_seq_nbits_if.slave  bus
);
    localparam int NS   = steps(W);
    localparam int IDXW = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NS - 1);

    if ((W % NIB) != 0 || W < NIB) begin : g_bad_width
        $fatal(1, "adder_seq_nbits: W must be a multiple of 4 and at least 4");
    end

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    s_q, s_d;
    logic            c_q, c_d;
    logic            co_q, co_d;
    logic [IDXW-1:0] idx_q, idx_d;

    logic [NIB-1:0]  slice_sum;
    logic            slice_co;
    logic [W-1:0]    s_shift;

    adder_4bits u_slice (
        .a  (a_q[NIB-1:0]),
        .b  (b_q[NIB-1:0]),
        .ci (c_q),
        .s  (slice_sum),
        .co (slice_co)
    );

    // New nibble enters at the top so the LS nibble lands at bit 0 after NS steps.
    assign s_shift = W'({slice_sum, s_q} >> NIB);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        c_d     = c_q;
        co_d    = co_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    c_d     = bus.ci;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_q >> NIB;
                b_d   = b_q >> NIB;
                s_d   = s_shift;
                c_d   = slice_co;
                idx_d = idx_q + IDXW'(1);
                if (idx_q == LAST_IDX) begin
                    co_d    = slice_co;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
            co_q    <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            c_q     <= c_d;
            co_q    <= co_d;
            idx_q   <= idx_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.s         = s_q;
    assign bus.co        = co_q;
endmodule

// File: doc/adder_seq_nbits.md
# adder_seq_nbits

Multi-cycle W-bit adder that sequences one shared `adder_4bits` carry-lookahead slice over W/4 consecutive cycles, least-significant nibble first. The slice's carry-out is registered and fed back as the next nibble's carry-in. The block trades latency for area in the approximate-arithmetic datapaths: partial-product accumulation stages use it wherever a full-width adder is not justified. Operands enter and results leave over valid/ready handshakes.

## Interface
- W, default 16: operand width in bits; must be a multiple of 4 and ≥ 4; NS = W/4 slice steps.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand offer.
- in_ready  out  1  block can accept; 1 only in IDLE.
- a  in  W  operand A; sampled on accept.
- b  in  W  operand B; sampled on accept.
- ci  in  1  carry-in; sampled on accept.
- out_valid  out  1  result available; 1 only in DONE.
- out_ready  in  1  consumer accepts result.
- s  out  W  sum; registered, stable while out_valid=1.
- co  out  1  carry-out of bit W-1; registered, stable while out_valid=1.
- busy  out  1  1 in RUN or DONE.

## Operation
- FSM states are IDLE, RUN and DONE. Reset state is IDLE.
- **IDLE.** in_ready=1. On in_valid=1:
  - a_reg←a, b_reg←b, c_reg←ci, idx←0.
  - Go to RUN.
- **RUN.** in_ready=0. The slice sees a_reg[3:0], b_reg[3:0] and c_reg. On each edge:
  - a_reg and b_reg shift right by 4.
  - The slice sum is shifted into s_reg from the top: s_reg←{sum, s_reg[W-1:4]}.
  - c_reg←slice co.
  - idx←idx+1.
  - When idx==NS-1, co_reg←slice co and go to DONE.
- **DONE.** out_valid=1. s=s_reg, co=co_reg.
  - On out_ready=1, go to IDLE. s and co keep their values until the next RUN step overwrites s_reg.
- **Arithmetic.**
  - {co,s} = a + b + ci, exact modulo 2^(W+1). No saturation or truncation.
  - The carry chain crosses nibble boundaries only through c_reg. No combinational path runs from nibble k to nibble k+1.
- **Handshakes.**
  - in_valid in RUN or DONE is ignored; the producer must hold its data.
  - out_ready outside DONE is ignored.
  - in_ready and out_valid are decoded from the state register only. Neither depends combinationally on any input.
- **Reset mid-operation.** The operation is aborted and its result discarded. No out_valid pulse is produced for it.

## Timing
- Reset values:
  - FSM state IDLE, so in_ready=1 while rst=1.
  - out_valid=0, busy=0, s=0, co=0.
  - a_reg, b_reg, c_reg and idx cleared to 0.
- **Accept.** An edge with in_valid & in_ready is accept edge T. busy=1 from T.
- **Latency.** The state becomes DONE on edge T+NS, so out_valid=1 in the cycle after edge T+NS.
  - W=16: four RUN edges.
  - W=4: one RUN edge, so DONE follows the edge after T.
- **Throughput.**
  - If out_ready=1 in the first DONE cycle, IDLE follows edge T+NS+1.
  - The next accept is possible at T+NS+2.
  - Minimum initiation interval is NS+2 cycles.
- **Back-pressure.** With out_ready=0, DONE is held indefinitely. s, co and out_valid stay constant; in_ready stays 0.
- **Async reset.** Assertion forces the IDLE outputs immediately, without waiting for an edge. Deassertion is treated as synchronized externally.

## Structure
- Package `adder_seq_pkg` holds:
  - the state enum {IDLE, RUN, DONE}, 2 bits;
  - the constant NIB = 4;
  - the function steps(W) = W/NIB.
- Sub-module: one `adder_4bits` instance, the only arithmetic in the block.
- Everything else is in this module: FSM, shift registers, idx counter of width $clog2(NS) (minimum 1), c_reg and co_reg.
- Elaboration check: fatal error if W%4 ≠ 0 or W < 4.

## Test plan
1. **Basic sum.** W=16, a=0x1234, b=0x4321, ci=0.
   - out_valid rises 4 edges after accept.
   - s=0x5555, co=0.
2. **Full carry ripple.** W=16, a=0xFFFF, b=0x0001, ci=0 → s=0x0000, co=1. Also a=0xFFFF, b=0xFFFF, ci=1 → s=0xFFFF, co=1.
3. **Back-pressure.** out_ready=0 for 6 cycles in DONE, with in_valid=1 and a new operand driven.
   - s and co are unchanged and in_ready=0.
   - The new operand is accepted only once IDLE is reached, one edge after out_ready=1.
   - The new operand produces its own correct sum.
4. **Reset mid-RUN.** Assert rst after 2 RUN edges.
   - in_ready=1, out_valid=0 and s=0 immediately.
   - The following operation 0x00FF+0x0F01 gives s=0x1000, co=0.
5. **Smallest width.** W=4, a=0x9, b=0x8, ci=1.
   - One-step latency.
   - s=0x2, co=1.
6. **Random streams.** 10k random operands for W=8, 16 and 32, with randomized in_valid and out_ready.
   - Every result equals a+b+ci.
   - Exactly one result per accept, in order.
